// File: rtl/memory_unit_if.sv
// Memory port bundle between the command processor (master) and memory_unit (slave).
interface memory_unit_if;
  logic        mem_block;
  logic [15:0] mem_locator;
  logic [15:0] mem_write;
  logic        mem_mode;
  logic [15:0] mem_read;
  logic        mem_response;
  logic        busy;
  logic        protect_fault;

  modport master (
    output mem_block, mem_locator, mem_write, mem_mode,
    input  mem_read, mem_response, busy, protect_fault
  );

  modport slave (
    input  mem_block, mem_locator, mem_write, mem_mode,
    output mem_read, mem_response, busy, protect_fault
  );
endinterface

// File: rtl/memory_unit.sv
// memory_unit: word-addressed 16-bit RAM behind the command processor's
// memory port. One serialized access per request, with programmable wait
// states and response width. Optional write protection of the low address
// range is compiled in with `define MEM_PROTECT_EN.
module memory_unit #(
  parameter int          ADDR_W      = 16,
  parameter int          LATENCY     = 0,
  parameter int          RESP_CYCLES = 1,
  parameter logic [15:0] PROTECT_TOP = 16'h0100
) (
  input  logic          clk,
  input  logic          rst,
  memory_unit_if.slave  bus
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP, S_DRAIN} state_t;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [3:0] RSP_M1 = 4'(RESP_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         data_q, data_d;
  logic                mode_q, mode_d;
  logic [15:0]         rd_q, rd_d;
  logic                resp_q, resp_d;
  logic                busy_q, busy_d;
  logic                fault_q, fault_d;
  logic                wr_en;
  logic                wr_blocked;
  logic [15:0]         ram_rdata;
  logic [15:0]         ram [0:DEPTH-1];

  // Upper locator bits are deliberately ignored (address wraps).
  logic unused_loc;
  assign unused_loc = ^bus.mem_locator;

`ifdef MEM_PROTECT_EN
  // Writes into the protected low range are dropped.
  assign wr_blocked = 32'(addr_q) < 32'(PROTECT_TOP);
`else
  assign wr_blocked = 1'b0;
  logic unused_ptop;
  assign unused_ptop = ^PROTECT_TOP;
`endif

  assign ram_rdata = ram[addr_q];

  // Next-state, latch and output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mode_d  = mode_q;
    rd_d    = rd_q;
    resp_d  = resp_q;
    fault_d = fault_q;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.mem_block) begin
          addr_d = bus.mem_locator[ADDR_W-1:0];
          data_d = bus.mem_write;
          mode_d = bus.mem_mode;
          if (LATENCY > 0) begin
            cnt_d   = LAT_M1;
            state_d = S_WAIT;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        if (mode_q) begin
          if (wr_blocked) fault_d = 1'b1;
          else            wr_en   = 1'b1;
        end else begin
          rd_d = ram_rdata;
        end
        resp_d  = 1'b1;
        cnt_d   = RSP_M1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (cnt_q == 4'd0) begin
          resp_d  = 1'b0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DRAIN: begin
        // A held request must drop before another one is accepted.
        if (!bus.mem_block) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
      rd_q    <= '0;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      rd_q    <= rd_d;
      resp_q  <= resp_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  // Storage array; never cleared, write suppressed during reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) ram[addr_q] <= data_q;
  end

  assign bus.mem_read      = rd_q;
  assign bus.mem_response  = resp_q;
  assign bus.busy          = busy_q;
  assign bus.protect_fault = fault_q;
endmodule

// File: tb/tb_memory_unit.sv
// Scoreboard bench for memory_unit: driver pushes expected responses,
// monitor checks data, latency, response width and the fault flag.
module tb_memory_unit;
  localparam int          AW    = 8;
  localparam int          LAT   = 3;
  localparam int          RSP   = 2;
  localparam logic [15:0] PTOP  = 16'h0080;
  localparam int          DEPTH = 1 << AW;

  typedef struct {
    bit          mode;
    int          idx;
    logic [15:0] data;
    bit          learn;
    int          cap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  memory_unit_if bus();

  memory_unit #(.ADDR_W(AW), .LATENCY(LAT), .RESP_CYCLES(RSP), .PROTECT_TOP(PTOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          resp_cnt = 0;
  exp_t        q[$];
  logic [15:0] mdl [DEPTH];
  bit          known [DEPTH];
  logic [15:0] last_read = 16'h0000;
  bit          exp_fault = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_prot(input int idx);
`ifdef MEM_PROTECT_EN
    return idx < int'(PTOP);
`else
    return (idx < 0);
`endif
  endfunction

  // Monitor: one sample per cycle, just after the active edge.
  initial begin
    bit prev = 1'b0;
    int hi_len = 0;
    exp_t e;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (bus.mem_response && !prev) begin
        resp_cnt++;
        hi_len = 1;
        if (q.size() == 0) begin
          chk("unexpected_response", 16'd1, 16'd0);
        end else begin
          e = q.pop_front();
          chk("resp_latency", 16'(cyc - e.cap), 16'(1 + LAT));
          chk("protect_fault", {15'd0, bus.protect_fault}, {15'd0, exp_fault});
          if (!e.mode) begin
            if (e.learn) begin
              mdl[e.idx]   = bus.mem_read;
              known[e.idx] = 1'b1;
            end else begin
              chk("read_data", bus.mem_read, e.data);
            end
            last_read = bus.mem_read;
          end else begin
            chk("read_hold_on_write", bus.mem_read, last_read);
          end
        end
      end else if (bus.mem_response) begin
        hi_len++;
      end else if (prev) begin
        chk("resp_width", 16'(hi_len), 16'(RSP));
      end
      prev = bus.mem_response;
    end
  end

  // One complete transaction; hold keeps the request up after the response.
  task automatic txn(input bit mode, input logic [15:0] loc, input logic [15:0] wd, input int hold);
    int t;
    int rc0;
    exp_t e;
    t = 0;
    while (bus.busy && t < 100) begin @(negedge clk); t++; end
    if (bus.busy) chk("idle_timeout", 16'd1, 16'd0);
    @(negedge clk);
    bus.mem_block   = 1'b1;
    bus.mem_locator = loc;
    bus.mem_write   = wd;
    bus.mem_mode    = mode;
    e.mode  = mode;
    e.idx   = int'(loc) % DEPTH;
    e.data  = mdl[e.idx];
    e.learn = 1'b0;
    e.cap   = cyc + 1;
    if (mode) begin
      if (is_prot(e.idx)) exp_fault = 1'b1;
      else begin mdl[e.idx] = wd; known[e.idx] = 1'b1; end
    end else begin
      e.learn = !known[e.idx];
    end
    q.push_back(e);
    rc0 = resp_cnt;
    @(negedge clk);
    chk("busy_after_capture", {15'd0, bus.busy}, 16'd1);
    // Latched request must ignore later input changes.
    bus.mem_locator = 16'($urandom);
    bus.mem_write   = 16'($urandom);
    bus.mem_mode    = ~mode;
    t = 0;
    while (!(resp_cnt != rc0 && !bus.mem_response) && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("resp_timeout", 16'd1, 16'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("busy_in_drain", {15'd0, bus.busy}, 16'd1);
      chk("single_access", 16'(resp_cnt - rc0), 16'd1);
    end
    bus.mem_block = 1'b0;
    @(negedge clk);
    chk("busy_after_release", {15'd0, bus.busy}, 16'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_read"},  bus.mem_read, 16'h0000);
    chk({tag, "_resp"},  {15'd0, bus.mem_response}, 16'd0);
    chk({tag, "_busy"},  {15'd0, bus.busy}, 16'd0);
    chk({tag, "_fault"}, {15'd0, bus.protect_fault}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    bus.mem_block   = 1'b0;
    bus.mem_locator = 16'h0000;
    bus.mem_write   = 16'h0000;
    bus.mem_mode    = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Write then read, wrap, protection.
    txn(1'b1, 16'h00C0, 16'hBEEF, 0);
    txn(1'b0, 16'h00C0, 16'h0000, 0);
    txn(1'b0, 16'h0010, 16'h0000, 0);
    txn(1'b1, 16'h01FF, 16'h1234, 0);
    txn(1'b0, 16'h00FF, 16'h0000, 0);
    txn(1'b0, 16'h0050, 16'h0000, 0);
    txn(1'b1, 16'h0050, 16'h5555, 0);
    txn(1'b0, 16'h0050, 16'h0000, 0);

    // Held request: exactly one access while mem_block stays high.
    txn(1'b1, 16'h00A0, 16'h1357, 10);
    txn(1'b0, 16'h00A0, 16'h0000, 0);

    // Reset partway through the wait states of a write.
    txn(1'b0, 16'h0300, 16'h0000, 0);
    @(negedge clk);
    bus.mem_block   = 1'b1;
    bus.mem_locator = 16'h0300;
    bus.mem_write   = 16'hAAAA;
    bus.mem_mode    = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.mem_block = 1'b0;
    @(negedge clk);
    chk_reset_outputs("abort");
    rst = 1'b0;
    last_read = 16'h0000;
    exp_fault = 1'b0;
    txn(1'b0, 16'h0300, 16'h0000, 0);

    // Randomized traffic around the protection boundary with wrapping locators.
    for (int n = 0; n < 60; n++) begin
      txn(1'($urandom_range(0, 1)),
          {8'($urandom), 8'(8'h70 + 8'($urandom_range(0, 31)))},
          16'($urandom), $urandom_range(0, 3));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 16'(q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
